regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 107 ++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Two-write / two-read register file with optional same-cycle write forwarding
// and a one-register-per-cycle clear sweep started by clr_req.
module regfile_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [1:0]        clr_state
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    clr_state_t        state;
    logic [ADDR_W-1:0] sweep_cnt;
    logic [DATA_W-1:0] regs [NUM_REGS];

    assign clr_state = state;

    // clr_req is a level request sampled only in IDLE; there is no ready signal,
    // the requester observes clr_busy/clr_done to track progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            state     <= IDLE;
            sweep_cnt <= '0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            // Later assignments win: port writes override the sweep zero,
            // and port 1 overrides port 0 on an address collision.
            if (state == SWEEP) begin
                regs[sweep_cnt] <= '0;
            end
            if (we0) begin
                regs[waddr0] <= wdata0;
            end
            if (we1) begin
                regs[waddr1] <= wdata1;
            end

            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state     <= SWEEP;
                        sweep_cnt <= '0;
                        clr_busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    sweep_cnt <= sweep_cnt + ADDR_W'(1);
                    if (sweep_cnt == LAST_IDX) begin
                        state    <= DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    // Forwarding looks only at port writes; sweep zeroing is never forwarded.
    always_comb begin
        rdata0 = regs[raddr0];
        rdata1 = regs[raddr1];
        if (BYPASS != 0) begin
            if (we0 && (waddr0 == raddr0)) rdata0 = wdata0;
            if (we1 && (waddr1 == raddr0)) rdata0 = wdata1;
            if (we0 && (waddr0 == raddr1)) rdata1 = wdata0;
            if (we1 && (waddr1 == raddr1)) rdata1 = wdata1;
        end
    end

endmodule
